dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: requester 0 is the pipeline memory stage (load/store), requester 1 is a secondary master (debug/DMA loader).
- Sequences each access through a request/grant/response handshake with a variable-latency memory.
- Generates the pipeline stall and bounds every access with a timeout.
- Sits between the memory-access stage and the data-memory macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- TIMEOUT, 16, maximum cycles spent in WAIT before an access is aborted with error.
- FIXED_PRIO, 0, 1 = requester 0 always wins; 0 = round-robin.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  per-requester access request; level, held until ack.
- we  in  2  per-requester write enable (1 = store, 0 = load).
- addr  in  2xADDR_W  per-requester byte address.
- wdata  in  2xDATA_W  per-requester store data.
- be  in  2xDATA_W/8  per-requester byte enables.
- ack  out  2  one-cycle completion pulse, per requester.
- rdata  out  DATA_W  load data, valid with ack, shared by both requesters.
- err  out  1  valid with ack; 1 = access timed out.
- stall  out  1  pipeline hold: req[0] & ~ack[0].
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory store data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_gnt  in  1  memory accepted the command this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset (async, rst=1) forces:
  - State IDLE.
  - All outputs 0: ack, rdata, err, mem_req, mem_we, mem_addr, mem_wdata, mem_be.
  - owner=0, rr_last=1 (so requester 0 wins the first round-robin tie), timeout counter=0.
  - stall is combinational, so it still reflects req[0]; the pipeline holds through reset.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Select the winner among asserted req bits.
  - FIXED_PRIO=1: requester 0 wins.
  - Round-robin: the requester not equal to rr_last wins a tie; a lone requester always wins.
  - On the next edge: latch owner and its we/addr/wdata/be into command registers, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - mem_req=1; mem_* driven from the command registers, stable until gnt.
  - mem_gnt=1 with a write: go to DONE.
  - mem_gnt=1 with a read: go to WAIT and clear the counter.
  - mem_gnt and mem_rvalid may arrive in the same cycle on a read: capture mem_rdata and go directly to DONE.
- WAIT:
  - mem_req=0; the counter increments each cycle.
  - mem_rvalid=1: capture mem_rdata into rdata, err=0, go to DONE.
  - Counter reaches TIMEOUT-1 without rvalid: rdata=0, err=1, go to DONE.
  - A late rvalid arriving while in IDLE is ignored.
- DONE:
  - ack[owner]=1 for exactly one cycle; rr_last<=owner; go to IDLE.
  - rdata/err hold their values until the next DONE.
- Latency:
  - Zero-wait write: 3 cycles from req to ack (IDLE, ISSUE, DONE).
  - Read with rvalid one cycle after gnt: 4 cycles.
- Back-to-back: a requester whose req stays high after ack is re-arbitrated in the IDLE cycle following DONE, so there is at least one idle cycle between accesses.
- A requester may not change addr/we/wdata/be while req is high. The arbiter latches them at IDLE, so later changes have no effect on the in-flight access.
- Deasserting req mid-transaction does not cancel the access; ack is still issued.
- Assertion: ack is never asserted for a requester whose req was low at the grant edge.
- The timeout counter is clog2(TIMEOUT) bits and saturates; it never wraps.

Decomposition:
- riscv_pkg additions:
  - arb_state_t enum {IDLE, ISSUE, WAIT, DONE}.
  - mem_cmd_t struct {we, addr, wdata, be}.
  - Constant DMEM_TIMEOUT_DEFAULT=16.
- One sub-module, rr_arbiter2: 2-input grant logic with rr_last state and a fixed-priority mode input.
- FSM, command registers and timeout counter stay in the top module.

Test Plan:
- Single store:
  - Stimulus: req=01, we[0]=1, addr=0x100, wdata=0xDEADBEEF, be=0xF, mem_gnt tied 1.
  - Response: mem_req high for exactly 1 cycle with matching fields; ack=01 three cycles after req; stall drops in the ack cycle.
- Single load:
  - Stimulus: req=10, addr=0x200; mem_gnt after 2 cycles; mem_rvalid 3 cycles later with 0x12345678.
  - Response: ack=10, rdata=0x12345678, err=0.
- Contention, round-robin:
  - Stimulus: req=11 held; both load; memory answers in 1 cycle.
  - Response: grant order 0,1,0,1; with FIXED_PRIO=1, only requester 0 is ever acked.
- Timeout:
  - Stimulus: load, mem_gnt=1, mem_rvalid never asserted.
  - Response: ack after TIMEOUT cycles in WAIT with err=1, rdata=0; the next access completes normally with err=0.
- Same-cycle grant and rvalid:
  - Stimulus: mem_gnt and mem_rvalid both high in ISSUE, mem_rdata=0xA5A5A5A5.
  - Response: WAIT is skipped; ack next cycle with rdata=0xA5A5A5A5.
- Reset mid-operation:
  - Stimulus: assert rst while in WAIT.
  - Response: all outputs 0 immediately with no ack pulse; after release, a pending req=01 is granted to requester 0 first.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    localparam int DMEM_TIMEOUT_DEFAULT = 16;
    localparam int DMEM_ADDR_W          = 32;
    localparam int DMEM_DATA_W          = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Latched memory command at the default port widths.
    typedef struct packed {
        logic                     we;
        logic [DMEM_ADDR_W-1:0]   addr;
        logic [DMEM_DATA_W-1:0]   wdata;
        logic [DMEM_DATA_W/8-1:0] be;
    } mem_cmd_t;

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter2.sv
// Two-input grant selection: fixed priority to requester 0, or round-robin
// where the requester that was not served last wins a tie.
module rr_arbiter2
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       fixed_prio_i,
    input  logic       upd_i,
    input  logic       upd_idx_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

    logic rr_last_q;

    // Remember who was served last; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      rr_last_q <= 1'b1;
        else if (upd_i) rr_last_q <= upd_idx_i;
    end

    // Pick a winner; a lone requester always wins.
    always_comb begin
        gnt_vld_o = |req_i;
        if (req_i == 2'b11) gnt_idx_o = fixed_prio_i ? 1'b0 : ~rr_last_q;
        else                gnt_idx_o = req_i[1] & ~req_i[0];
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the pipeline memory stage (0) and a
// secondary master (1). Each access runs IDLE -> ISSUE -> [WAIT] -> DONE,
// with reads bounded by a saturating timeout counter.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = DMEM_TIMEOUT_DEFAULT,
    parameter int FIXED_PRIO = 0
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req,
    input  logic [1:0]               we,
    input  logic [1:0][ADDR_W-1:0]   addr,
    input  logic [1:0][DATA_W-1:0]   wdata,
    input  logic [1:0][DATA_W/8-1:0] be,
    output logic [1:0]               ack,
    output logic [DATA_W-1:0]        rdata,
    output logic                     err,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [DATA_W/8-1:0]      mem_be,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int              BE_W    = DATA_W / 8;
    localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    // Command at this instance's widths (package type covers the defaults).
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } cmd_t;

    arb_state_t        state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              win_vld, win_idx;

    rr_arbiter2 u_arb (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .fixed_prio_i (1'(FIXED_PRIO != 0)),
        .upd_i        (state_q == DONE),
        .upd_idx_i    (owner_q),
        .gnt_vld_o    (win_vld),
        .gnt_idx_o    (win_idx)
    );

    // State, command, owner, timeout counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state: latch the winner in IDLE, then follow the memory handshake.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    owner_d     = win_idx;
                    cmd_d.we    = we[win_idx];
                    cmd_d.addr  = addr[win_idx];
                    cmd_d.wdata = wdata[win_idx];
                    cmd_d.be    = be[win_idx];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    if (cmd_q.we) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else if (mem_rvalid) begin
                        // Grant and data in the same cycle: skip WAIT.
                        rdata_d = mem_rdata;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: memory command only while issuing, ack pulse in DONE.
    always_comb begin
        ack          = '0;
        ack[owner_q] = (state_q == DONE);
        mem_req      = (state_q == ISSUE);
        mem_we       = mem_req ? cmd_q.we    : 1'b0;
        mem_addr     = mem_req ? cmd_q.addr  : '0;
        mem_wdata    = mem_req ? cmd_q.wdata : '0;
        mem_be       = mem_req ? cmd_q.be    : '0;
        rdata        = rdata_q;
        err          = err_q;
        stall        = req[0] & ~ack[0];
    end

endmodule
